// File: rtl/clk_div_prog_pkg.sv
// Shared constants and types for the programmable clock divider.
// Ratios below MIN_DIV cannot produce a 50 % duty output.
package clk_div_pkg;
   localparam int MIN_DIV     = 2;
   localparam int CNT_W_DEF   = 8;
   localparam int DEF_DIV_DEF = 7;

   typedef logic [CNT_W_DEF-1:0] div_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// The divider itself connects through the slave modport.
interface clk_div_prog_if
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             en;
   logic             load;
   logic [CNT_W-1:0] div_ratio;
   logic             clk_out;
   logic             active;
   logic             cfg_err;

   modport master (
      output en, load, div_ratio,
      input  clk_out, active, cfg_err
   );

   modport slave (
      input  en, load, div_ratio,
      output clk_out, active, cfg_err
   );
endinterface

// File: rtl/clk_div_prog_neg_retime.sv
// Negedge retime flop supplying the half-cycle extension for odd ratios.
// Kept as its own instance so dual-edge constraints target one cell.
module clk_div_neg_retime (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) q <= 1'b0;
      else      q <= d;
   end
endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50 % duty integer divider; ratio changes
// and stops only take effect on period boundaries.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = DEF_DIV_DEF
) (
   input logic           clk_in,
   input logic           rst,
   clk_div_prog_if.slave bus
);
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DEF_N = cnt_t'(DEF_DIV);
   localparam cnt_t MIN_N = cnt_t'(MIN_DIV);
   localparam cnt_t ONE   = cnt_t'(1);

   state_t state;
   cnt_t   cnt;
   cnt_t   cur_n;
   cnt_t   pend_n;
   logic   pos_q;
   logic   neg_q;
   logic   active_q;
   logic   err_q;

   cnt_t half;
   cnt_t cnt_nxt;
   logic wrap;

   assign half    = cur_n >> 1;
   assign cnt_nxt = cnt + ONE;
   assign wrap    = (cnt == cur_n - ONE);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cur_n    <= DEF_N;
         pend_n   <= DEF_N;
         pos_q    <= 1'b0;
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (bus.load) begin
            if (bus.div_ratio >= MIN_N) begin
               pend_n <= bus.div_ratio;
               err_q  <= 1'b0;
            end else begin
               err_q  <= 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               cnt   <= '0;
               cur_n <= pend_n;
               pos_q <= bus.en;
               if (bus.en) begin
                  state    <= RUN;
                  active_q <= 1'b1;
               end
            end
            RUN: begin
               if (wrap) begin
                  cnt   <= '0;
                  cur_n <= pend_n;
                  pos_q <= bus.en;
                  if (!bus.en) begin
                     state    <= IDLE;
                     active_q <= 1'b0;
                  end
               end else begin
                  cnt   <= cnt_nxt;
                  pos_q <= (cnt_nxt < half);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Gating with the odd bit at D keeps the output OR free of extra inputs.
   clk_div_neg_retime u_neg (
      .clk (clk_in),
      .rst (rst),
      .d   (pos_q & cur_n[0]),
      .q   (neg_q)
   );

   assign bus.clk_out = pos_q | neg_q;
   assign bus.active  = active_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: per-cycle scoreboard against a timing
// model plus edge-timestamp checks of period and high time.
module tb_clk_div_prog;
   logic clk_in = 1'b0;
   logic rst    = 1'b0;

   clk_div_prog_if #(.CNT_W(8)) bus ();

   clk_div_prog #(.CNT_W(8), .DEF_DIV(7)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit act;
      bit hi1;
      bit hi2;
      bit err;
   } exp_t;

   typedef struct {
      bit         en;
      bit         load;
      logic [7:0] ratio;
      int         cyc;
      int         per;
      int         hi;
   } seg_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   ncyc  = 0;

   bit m_run, m_err;
   int m_p, m_n, m_pend;

   time t_rise = 0;
   time per_t  = 0;
   time hi_t   = 0;

   always @(posedge bus.clk_out) begin
      per_t  = $time - t_rise;
      t_rise = $time;
   end

   always @(negedge bus.clk_out) hi_t = $time - t_rise;

   task automatic model_reset();
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_p    = 0;
      m_n    = 7;
      m_pend = 7;
   endtask

   task automatic model_edge(input bit e, input bit l, input int r);
      int old;
      old = m_pend;
      if (l) begin
         if (r >= 2) begin
            m_pend = r;
            m_err  = 1'b0;
         end else begin
            m_err  = 1'b1;
         end
      end
      if (!m_run || m_p == m_n - 1) begin
         m_n   = old;
         m_p   = 0;
         m_run = e;
      end else begin
         m_p++;
      end
   endtask

   function automatic exp_t model_out();
      exp_t x;
      int   h;
      h     = m_n / 2;
      x.act = m_run;
      x.hi1 = m_run && (m_p < h || (m_n % 2 == 1 && m_p == h));
      x.hi2 = m_run && (m_p < h);
      x.err = m_err;
      return x;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   task automatic step(input bit e, input bit l, input logic [7:0] r);
      exp_t x;
      logic a1, c1, f1, c2;
      bus.en        = e;
      bus.load      = l;
      bus.div_ratio = r;
      @(posedge clk_in);
      model_edge(e, l, int'(r));
      sb.push_back(model_out());
      #1;
      a1       = bus.active;
      c1       = bus.clk_out;
      f1       = bus.cfg_err;
      bus.load = 1'b0;
      @(negedge clk_in);
      #1;
      c2 = bus.clk_out;
      x  = sb.pop_front();
      ncyc++;
      total++;
      if ({a1, c1, c2, f1} !== {x.act, x.hi1, x.hi2, x.err}) begin
         bad++;
         $display("FAIL cyc%0d act/clk_hi/clk_lo/err: got %b%b%b%b want %b%b%b%b",
                  ncyc, a1, c1, c2, f1, x.act, x.hi1, x.hi2, x.err);
      end
   endtask

   seg_t segs[5];

   initial begin
      int  k;
      bit  ok;

      segs[0] = '{1'b1, 1'b0, 8'd0, 21, 70, 35};
      segs[1] = '{1'b1, 1'b1, 8'd4, 30, 40, 20};
      segs[2] = '{1'b1, 1'b1, 8'd1,  3, 40, 20};
      segs[3] = '{1'b1, 1'b1, 8'd0,  3, 40, 20};
      segs[4] = '{1'b1, 1'b1, 8'd5, 30, 50, 25};

      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.div_ratio = '0;
      model_reset();

      #3;
      check("rst_active", bus.active, 0);
      check("rst_clk_out", bus.clk_out, 0);
      check("rst_cfg_err", bus.cfg_err, 0);

      @(negedge clk_in);
      #2;
      rst = 1'b1;

      foreach (segs[i]) begin
         step(segs[i].en, segs[i].load, segs[i].ratio);
         for (int c = 1; c < segs[i].cyc; c++) step(segs[i].en, 1'b0, 8'd0);
         check($sformatf("seg%0d_period", i), per_t, segs[i].per);
         check($sformatf("seg%0d_high", i), hi_t, segs[i].hi);
      end

      // stop request while a 6-cycle period is running
      step(1'b1, 1'b1, 8'd6);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 8'd0);
      ok = 1'b0;
      for (k = 0; k < 20 && !ok; k++) begin
         if (m_n == 6 && m_p == 0) ok = 1'b1;
         else step(1'b1, 1'b0, 8'd0);
      end
      check("sync_n6", ok, 1);
      step(1'b0, 1'b0, 8'd0);
      check("mid_en_drop_active", bus.active, 1);
      ok = 1'b0;
      for (k = 0; k < 20 && !ok; k++) begin
         step(1'b0, 1'b0, 8'd0);
         if (!m_run) ok = 1'b1;
      end
      check("stop_reached", ok, 1);
      check("stop_active", bus.active, 0);
      check("n6_period", per_t, 60);
      check("n6_high", hi_t, 30);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      check("restart_clk_out", bus.clk_out, 1);
      for (int c = 0; c < 14; c++) step(1'b1, 1'b0, 8'd0);

      // load landing on the wrap edge of a 3-cycle period
      step(1'b1, 1'b1, 8'd3);
      for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 8'd0);
      ok = 1'b0;
      for (k = 0; k < 10 && !ok; k++) begin
         if (m_n == 3 && m_p == 2) ok = 1'b1;
         else step(1'b1, 1'b0, 8'd0);
      end
      check("sync_n3_wrap", ok, 1);
      step(1'b1, 1'b1, 8'd8);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 8'd0);
      check("wrap_load_old_period", per_t, 30);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 8'd0);
      check("n8_period", per_t, 80);
      check("n8_high", hi_t, 40);

      // asynchronous reset while the output is high
      ok = 1'b0;
      for (k = 0; k < 10 && !ok; k++) begin
         if (m_p == 0) ok = 1'b1;
         else step(1'b1, 1'b0, 8'd0);
      end
      check("sync_high", ok, 1);
      check("pre_rst_clk_out", bus.clk_out, 1);
      rst = 1'b0;
      #1;
      check("async_clk_out", bus.clk_out, 0);
      check("async_active", bus.active, 0);
      check("async_cnt", dut.cnt, 0);
      model_reset();
      @(negedge clk_in);
      #1;
      rst = 1'b1;
      for (int c = 0; c < 21; c++) step(1'b1, 1'b0, 8'd0);
      check("post_rst_period", per_t, 70);
      check("post_rst_high", hi_t, 35);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider with 50 % duty cycle for both even and odd ratios. It generalises the fixed divide-by-7 dual-edge divider in a parametrised way:
- the ratio is loaded at run time
- ratio changes take effect only on period boundaries, so there are no glitches or runt pulses
- an enable gates the output cleanly

It sits beside the clock generators and feeds slow peripheral and test clocks.

## Interface
- `CNT_W`, 8: counter and ratio width; legal ratios are 2 .. 2^CNT_W−1.
- `DEF_DIV`, 7: ratio in force after reset. Must be ≥2 and < 2^CNT_W.

Ports:
- `clk_in`  in  1  source clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  divider enable, sampled on `clk_in` posedge.
- `load`  in  1  one-cycle strobe; captures `div_ratio` on posedge.
- `div_ratio`  in  CNT_W  requested ratio N.
- `clk_out`  out  1  divided clock.
- `active`  out  1  high while a divided period is in progress.
- `cfg_err`  out  1  sticky; set when an illegal ratio is loaded.

## Operation
- Registers:
  - `cnt` (CNT_W), posedge counter.
  - `cur_n`, ratio in force.
  - `pend_n`, ratio waiting to be applied.
  - `pos_q`, posedge-generated phase.
  - `neg_q`, negedge retime of `pos_q`.
- Reset (`rst` low) forces: `cnt`=0, `cur_n`=`pend_n`=DEF_DIV, `pos_q`=`neg_q`=0, `active`=0, `cfg_err`=0, `clk_out`=0. Recovery is on the first posedge after `rst` rises.
- Load, posedge with `load`=1:
  - If `div_ratio` ≥2: `pend_n` ← `div_ratio`, and `cfg_err` ← 0.
  - Otherwise (0 or 1): `pend_n` is unchanged and `cfg_err` ← 1.
- States: IDLE (`active`=0) and RUN (`active`=1).
- IDLE:
  - `cnt`=0, `pos_q`=0, and `cur_n` ← `pend_n` every posedge.
  - `en`=1 at a posedge enters RUN with `cnt`=0 and `pos_q`=1.
- RUN:
  - `cnt` counts 0..`cur_n`−1, then wraps to 0.
  - On wrap, `cur_n` ← `pend_n` (the value held before that edge).
  - If `en`=0 at the wrap edge, the block returns to IDLE with `pos_q`=0. An `en` drop mid-period never truncates the period.
- Phase generation, with H = `cur_n`>>1:
  - `pos_q`=1 for `cnt` in [0, H−1], else 0.
  - `neg_q` samples `pos_q` on every negedge; it is cleared by reset.
  - Even `cur_n`: `clk_out` = `pos_q`.
  - Odd `cur_n`: `clk_out` = `pos_q` | `neg_q`.
- Simultaneous `load` and wrap on the same edge: the old `pend_n` is applied, and the newly loaded value applies at the following wrap.
- Reset mid-period: output drops asynchronously, then the block restarts from IDLE.

## Timing
- Period: exactly `cur_n` `clk_in` cycles.
- High time:
  - Even N: N/2 cycles.
  - Odd N: (N−1)/2 + 0.5 cycles, with the fall on a negedge.
- Start-up: `en` sampled high at posedge k makes `clk_out` rise after edge k (clk-to-q only, no extra latency).
- `clk_out` rising edges always coincide with posedges where `cnt` becomes 0.
- Ratio change: the new period starts at the first wrap after the load edge. There is no period of intermediate length.
- Stop: `active` falls at the wrap edge where `en`=0 is sampled. `clk_out` is already low at that point, so the output never shows a short high pulse.
- `clk_out` is combinational OR of two flops. The OR is the last logic stage and has no other inputs.

## Structure
- Package `clk_div_pkg`:
  - `localparam MIN_DIV = 2`.
  - Default `CNT_W`/`DEF_DIV` constants.
  - Typedef `div_t` = logic [CNT_W−1:0].
- Sub-module `clk_div_neg_retime`:
  - A negedge flop with async active-low reset that produces `neg_q`.
  - Isolated so that dual-edge timing constraints attach to a single instance.
- Top module holds the counter, ratio registers, IDLE/RUN control and the output OR.

## Test plan
- Reset then `en`=1 with default 7: `clk_out` period is 7 cycles, high 3.5 cycles, rising on posedges and falling on negedges; `active`=1.
- `load` `div_ratio`=4 mid-period while running at 7: current 7-cycle period completes; the next period is 4 cycles with high time 2 cycles.
- `load` ratio 1, then ratio 0: `cfg_err`=1 and the ratio stays unchanged. A subsequent `load` of 5 clears `cfg_err` and produces 5-cycle periods (high 2.5).
- `en` dropped at `cnt`=1 with N=6: the period finishes (3 high, 3 low), then `active`=0 and `clk_out` is held 0. Re-asserting `en` starts a full period immediately.
- `load` coinciding with the wrap edge (N=3, load 8): one more 3-cycle period, then 8-cycle periods.
- `rst` asserted while `clk_out`=1: `clk_out`, `active` and `cnt` are 0 immediately. After release, the ratio is 7 and behaviour restarts as in scenario 1.
